projectile_pool: RTL and testbench

Parametrised projectile manager: the generalised successor of the single-direction bullet block. It holds up to SLOTS projectiles in a register array and launches them from a player position on a fire button press. During each frame-update window it moves them by SPEED in a configurable direction and retires any that leave the screen. During active display it reports per-pixel projectile coverage and sprite offsets to the pixel pipeline, and it accepts per-pixel hit feedback. It sits between the player/input logic and the pixel colour mux, beside the sprite ROM and colour palette.

---
 rtl/projectile_pool.sv | 238 +++++++++++++++++++++++
 tb/tb_projectile_pool.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/projectile_pool.sv
// Projectile pool: launches sprites on a fire press, advances or retires them once per
// frame-update window, and reports per-pixel coverage, sprite offsets and hit removal.
module projectile_pool #(
  parameter int SLOTS    = 16,
  parameter int SIZE     = 32,
  parameter int SPEED    = 8,
  parameter int DIR      = 0,
  parameter int Y_MAX    = 1079,
  parameter int X_OFFSET = 48,
  parameter int COOLDOWN = 4
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     i_fire,
  input  logic [11:0]              i_x_axis,
  input  logic [10:0]              i_y_axis,
  input  logic [11:0]              i_display_col,
  input  logic [10:0]              i_display_row,
  input  logic                     i_calc,
  input  logic                     i_hit,
  output logic                     o_bullet_on,
  output logic [$clog2(SLOTS)-1:0] o_bullet_slot,
  output logic [$clog2(SIZE)-1:0]  o_sprite_x,
  output logic [$clog2(SIZE)-1:0]  o_sprite_y,
  output logic [$clog2(SLOTS):0]   o_active_count,
  output logic                     o_full,
  output logic                     o_overflow,
  output logic                     o_busy
);

  localparam int SW = $clog2(SLOTS);
  localparam int CW = SW + 1;
  localparam int ZW = $clog2(SIZE);
  localparam int DW = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_INSERT, S_MOVE} state_t;

  state_t          r_state, w_state_next;
  logic [SW-1:0]   r_idx, w_idx_next;

  logic            r_fire_d, r_calc_d, r_calc_rise;
  logic            r_pending;
  logic [DW-1:0]   r_cooldown;
  logic [11:0]     r_launch_x;
  logic [10:0]     r_launch_y;

  logic [SLOTS-1:0] r_valid;
  logic [11:0]      r_x [SLOTS];
  logic [10:0]      r_y [SLOTS];

  logic            r_bullet_on, r_full, r_overflow;
  logic [SW-1:0]   r_bullet_slot;
  logic [ZW-1:0]   r_sprite_x, r_sprite_y;
  logic [CW-1:0]   r_active_count;

  logic            w_fire_take, w_free_any, w_insert, w_move_clear, w_hit_clear;
  logic [SW-1:0]   w_free_idx;
  logic [11:0]     w_y_sum;
  logic [10:0]     w_y_diff, w_y_next;
  logic [SLOTS-1:0] w_cover;
  logic            w_on;
  logic [SW-1:0]   w_slot;
  logic [ZW-1:0]   w_sx, w_sy;
  logic [CW-1:0]   w_count;

  // Input edge detection; the calc edge is registered once more before the FSM sees it.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_fire_d    <= 1'b1;
      r_calc_d    <= 1'b0;
      r_calc_rise <= 1'b0;
    end else begin
      r_fire_d    <= i_fire;
      r_calc_d    <= i_calc;
      r_calc_rise <= i_calc & ~r_calc_d;
    end
  end

  assign w_fire_take = r_fire_d & ~i_fire & (r_cooldown == '0);
  assign w_insert    = (r_state == S_INSERT) && r_pending && w_free_any;
  assign w_hit_clear = i_hit & ~i_calc & r_bullet_on;

  // A fire edge in the INSERT cycle wins over the clear, so it waits for the next frame.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_pending  <= 1'b0;
      r_cooldown <= '0;
      r_launch_x <= '0;
      r_launch_y <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= 1'b0;
      if (r_state == S_INSERT) begin
        if (r_pending) begin
          r_pending <= 1'b0;
          if (w_free_any) r_cooldown <= DW'(COOLDOWN);
          else            r_overflow <= 1'b1;
        end else if (r_cooldown != '0) begin
          r_cooldown <= r_cooldown - DW'(1);
        end
      end
      if (w_fire_take) begin
        r_pending  <= 1'b1;
        r_launch_x <= i_x_axis + 12'(X_OFFSET);
        r_launch_y <= i_y_axis;
      end
    end
  end

  // NOTE: every signal driven in always_comb gets a default first, so no path infers a latch.
  always_comb begin
    w_free_any = 1'b0;
    w_free_idx = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (!r_valid[i]) begin
        w_free_any = 1'b1;
        w_free_idx = SW'(i);
      end
    end
  end

  always_comb begin
    w_y_sum  = {1'b0, r_y[r_idx]} + 12'(SPEED);
    w_y_diff = r_y[r_idx] - 11'(SPEED);
    if (DIR == 0) begin
      w_move_clear = r_y[r_idx] < 11'(SPEED);
      w_y_next     = w_y_diff;
    end else begin
      w_move_clear = w_y_sum > 12'(Y_MAX);
      w_y_next     = w_y_sum[10:0];
    end
  end

  // NOTE: only the valid bits are reset; positions are don't-care until a slot is written.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_valid <= '0;
    end else begin
      if (w_insert) begin
        r_valid[w_free_idx] <= 1'b1;
        r_x[w_free_idx]     <= r_launch_x;
        r_y[w_free_idx]     <= r_launch_y;
      end
      if (r_state == S_MOVE && r_valid[r_idx]) begin
        if (w_move_clear) r_valid[r_idx] <= 1'b0;
        else              r_y[r_idx]     <= w_y_next;
      end
      if (w_hit_clear) r_valid[r_bullet_slot] <= 1'b0;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    case (r_state)
      S_IDLE:   if (r_calc_rise) w_state_next = S_INSERT;
      S_INSERT: begin
        w_state_next = S_MOVE;
        w_idx_next   = '0;
      end
      S_MOVE: begin
        if (r_idx == SW'(SLOTS - 1)) w_state_next = S_IDLE;
        else                         w_idx_next   = r_idx + SW'(1);
      end
      default:  w_state_next = S_IDLE;
    endcase
  end

  // Coverage uses sums one bit wider so sprites near the far edges do not wrap.
  always_comb begin
    w_cover = '0;
    for (int i = 0; i < SLOTS; i++) begin
      w_cover[i] = r_valid[i]
                 && (i_display_row >= r_y[i])
                 && ({1'b0, i_display_row} < ({1'b0, r_y[i]} + 12'(SIZE)))
                 && (i_display_col >= r_x[i])
                 && ({1'b0, i_display_col} < ({1'b0, r_x[i]} + 13'(SIZE)));
    end
  end

  always_comb begin
    w_on   = 1'b0;
    w_slot = '0;
    w_sx   = '0;
    w_sy   = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (w_cover[i]) begin
        w_on   = 1'b1;
        w_slot = SW'(i);
        w_sx   = ZW'(i_display_col - r_x[i]);
        w_sy   = ZW'(i_display_row - r_y[i]);
      end
    end
  end

  always_comb begin
    w_count = '0;
    for (int i = 0; i < SLOTS; i++) w_count = w_count + CW'(r_valid[i]);
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_bullet_on    <= 1'b0;
      r_bullet_slot  <= '0;
      r_sprite_x     <= '0;
      r_sprite_y     <= '0;
      r_active_count <= '0;
      r_full         <= 1'b0;
    end else begin
      r_bullet_on    <= w_on;
      r_bullet_slot  <= w_slot;
      r_sprite_x     <= w_sx;
      r_sprite_y     <= w_sy;
      r_active_count <= w_count;
      r_full         <= (w_count == CW'(SLOTS));
    end
  end

  assign o_bullet_on    = r_bullet_on;
  assign o_bullet_slot  = r_bullet_slot;
  assign o_sprite_x     = r_sprite_x;
  assign o_sprite_y     = r_sprite_y;
  assign o_active_count = r_active_count;
  assign o_full         = r_full;
  assign o_overflow     = r_overflow;
  assign o_busy         = (r_state != S_IDLE);

endmodule

// File: tb/tb_projectile_pool.sv
// Bench for projectile_pool: two instances (DIR=0/COOLDOWN=4 and DIR=1/COOLDOWN=0) share
// one stimulus stream and are compared against a slot-list reference model.
module tb_projectile_pool;

  localparam int SLOTS    = 16;
  localparam int SPEED    = 8;
  localparam int Y_MAX    = 1079;
  localparam int X_OFFSET = 48;

  logic clk = 1'b0;
  logic rst, fire, calc, hit;
  logic [11:0] x_axis, col;
  logic [10:0] y_axis, row;

  logic [1:0]      on, full, ovf, busy;
  logic [1:0][3:0] slot;
  logic [1:0][4:0] sx, sy, cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  projectile_pool #(.DIR(0), .COOLDOWN(4)) dut_a (
    .i_clock(clk), .i_reset(rst), .i_fire(fire), .i_x_axis(x_axis), .i_y_axis(y_axis),
    .i_display_col(col), .i_display_row(row), .i_calc(calc), .i_hit(hit),
    .o_bullet_on(on[0]), .o_bullet_slot(slot[0]), .o_sprite_x(sx[0]), .o_sprite_y(sy[0]),
    .o_active_count(cnt[0]), .o_full(full[0]), .o_overflow(ovf[0]), .o_busy(busy[0]));

  projectile_pool #(.DIR(1), .COOLDOWN(0)) dut_b (
    .i_clock(clk), .i_reset(rst), .i_fire(fire), .i_x_axis(x_axis), .i_y_axis(y_axis),
    .i_display_col(col), .i_display_row(row), .i_calc(calc), .i_hit(hit),
    .o_bullet_on(on[1]), .o_bullet_slot(slot[1]), .o_sprite_x(sx[1]), .o_sprite_y(sy[1]),
    .o_active_count(cnt[1]), .o_full(full[1]), .o_overflow(ovf[1]), .o_busy(busy[1]));

  // Reference model: a list of projectiles per instance, updated by the rules directly.
  bit m_valid [2][SLOTS];
  int m_x     [2][SLOTS];
  int m_y     [2][SLOTS];
  bit m_pend  [2];
  int m_cd    [2];
  int m_lx    [2];
  int m_ly    [2];
  int m_ovf   [2];

  function automatic int dir_of(int k);  return k; endfunction
  function automatic int cool_of(int k); return (k == 0) ? 4 : 0; endfunction

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < SLOTS; i++) m_valid[k][i] = 1'b0;
      m_pend[k] = 1'b0;
      m_cd[k]   = 0;
      m_ovf[k]  = 0;
    end
  endfunction

  function automatic void model_fire(int x, int y);
    for (int k = 0; k < 2; k++) begin
      if (m_cd[k] == 0) begin
        m_pend[k] = 1'b1;
        m_lx[k]   = (x + X_OFFSET) % 4096;
        m_ly[k]   = y;
      end
    end
  endfunction

  function automatic void model_frame();
    for (int k = 0; k < 2; k++) begin
      int free;
      m_ovf[k] = 0;
      if (m_pend[k]) begin
        m_pend[k] = 1'b0;
        free = -1;
        for (int i = SLOTS - 1; i >= 0; i--) if (!m_valid[k][i]) free = i;
        if (free >= 0) begin
          m_valid[k][free] = 1'b1;
          m_x[k][free]     = m_lx[k];
          m_y[k][free]     = m_ly[k];
          m_cd[k]          = cool_of(k);
        end else begin
          m_ovf[k] = 1;
        end
      end else if (m_cd[k] > 0) begin
        m_cd[k] = m_cd[k] - 1;
      end
      for (int i = 0; i < SLOTS; i++) begin
        if (m_valid[k][i]) begin
          if (dir_of(k) == 0) begin
            if (m_y[k][i] < SPEED) m_valid[k][i] = 1'b0;
            else                   m_y[k][i] = m_y[k][i] - SPEED;
          end else begin
            if (m_y[k][i] + SPEED > Y_MAX) m_valid[k][i] = 1'b0;
            else                           m_y[k][i] = m_y[k][i] + SPEED;
          end
        end
      end
    end
  endfunction

  function automatic int model_cover(int k, int c, int r);
    for (int i = 0; i < SLOTS; i++)
      if (m_valid[k][i] && r >= m_y[k][i] && r < m_y[k][i] + 32 &&
          c >= m_x[k][i] && c < m_x[k][i] + 32) return i;
    return -1;
  endfunction

  function automatic int model_count(int k);
    int n = 0;
    for (int i = 0; i < SLOTS; i++) if (m_valid[k][i]) n++;
    return n;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_zero(string tag);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("%s_on[%0d]", tag, k),    32'(on[k]),   0);
      check($sformatf("%s_slot[%0d]", tag, k),  32'(slot[k]), 0);
      check($sformatf("%s_sx[%0d]", tag, k),    32'(sx[k]),   0);
      check($sformatf("%s_sy[%0d]", tag, k),    32'(sy[k]),   0);
      check($sformatf("%s_cnt[%0d]", tag, k),   32'(cnt[k]),  0);
      check($sformatf("%s_full[%0d]", tag, k),  32'(full[k]), 0);
      check($sformatf("%s_ovf[%0d]", tag, k),   32'(ovf[k]),  0);
      check($sformatf("%s_busy[%0d]", tag, k),  32'(busy[k]), 0);
    end
  endtask

  task automatic check_pixel(int c, int r, string tag);
    for (int k = 0; k < 2; k++) begin
      int s, eon, eslot, ex, ey;
      s     = model_cover(k, c, r);
      eon   = (s >= 0) ? 1 : 0;
      eslot = (s >= 0) ? s : 0;
      ex    = (s >= 0) ? c - m_x[k][s] : 0;
      ey    = (s >= 0) ? r - m_y[k][s] : 0;
      check($sformatf("%s_on[%0d]", tag, k),   32'(on[k]),   eon);
      check($sformatf("%s_slot[%0d]", tag, k), 32'(slot[k]), eslot);
      check($sformatf("%s_sx[%0d]", tag, k),   32'(sx[k]),   ex);
      check($sformatf("%s_sy[%0d]", tag, k),   32'(sy[k]),   ey);
    end
  endtask

  task automatic check_counts(string tag);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("%s_cnt[%0d]", tag, k),  32'(cnt[k]),  model_count(k));
      check($sformatf("%s_full[%0d]", tag, k), 32'(full[k]), (model_count(k) == SLOTS) ? 1 : 0);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; fire = 1'b1; calc = 1'b0; hit = 1'b0;
    x_axis = '0; y_axis = '0; col = '0; row = '0;
    step(2);
    check_zero("reset");
    rst = 1'b0;
    model_reset();
    step(1);
  endtask

  task automatic press(int x, int y);
    x_axis = 12'(x);
    y_axis = 11'(y);
    fire   = 1'b0;
    step(1);
    fire   = 1'b1;
    step(1);
    model_fire(x, y);
  endtask

  task automatic probe(int c, int r, string tag);
    col = 12'(c);
    row = 11'(r);
    step(1);
    check_pixel(c, r, tag);
  endtask

  task automatic probe_all(string tag);
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < SLOTS; i++)
        if (m_valid[k][i]) begin
          int c, r;
          c = m_x[k][i] + int'($urandom_range(0, 31));
          r = m_y[k][i] + int'($urandom_range(0, 31));
          if (c > 4095) c = 4095;
          probe(c, r, tag);
        end
  endtask

  // One calc window; optionally a hit on a dut_b slot while calc is still high.
  task automatic frame(int hit_slot);
    int nb[2], no[2];
    for (int k = 0; k < 2; k++) begin nb[k] = 0; no[k] = 0; end
    calc = 1'b1;
    for (int t = 0; t < SLOTS + 4; t++) begin
      step(1);
      for (int k = 0; k < 2; k++) begin
        nb[k] += int'(busy[k]);
        no[k] += int'(ovf[k]);
      end
    end
    model_frame();
    if (hit_slot >= 0) begin
      int c, r;
      c = m_x[1][hit_slot] + 4;
      r = m_y[1][hit_slot] + 4;
      col = 12'(c);
      row = 11'(r);
      step(1);
      check_pixel(c, r, "calc_hit_pre");
      hit = 1'b1;
      step(1);
      hit = 1'b0;
    end
    calc = 1'b0;
    for (int t = 0; t < 3; t++) begin
      step(1);
      for (int k = 0; k < 2; k++) begin
        nb[k] += int'(busy[k]);
        no[k] += int'(ovf[k]);
      end
    end
    for (int k = 0; k < 2; k++) begin
      check($sformatf("busy_cycles[%0d]", k), nb[k], SLOTS + 1);
      check($sformatf("overflow_pulses[%0d]", k), no[k], m_ovf[k]);
    end
    check_counts("frame");
  endtask

  task automatic hit_pix(int c, int r);
    col = 12'(c);
    row = 11'(r);
    step(1);
    check_pixel(c, r, "hit_pre");
    hit = 1'b1;
    step(1);
    hit = 1'b0;
    for (int k = 0; k < 2; k++) begin
      int s;
      s = model_cover(k, c, r);
      if (s >= 0) m_valid[k][s] = 1'b0;
    end
    step(1);
    check_pixel(c, r, "hit_post");
    check_counts("hit_post");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // First launch: dut_a ends at (148, 892), dut_b at (148, 908).
    press(100, 900);
    frame(-1);
    probe(148, 892, "launch_a");
    check("launch_a_on", 32'(on[0]), 1);
    check("launch_a_slot", 32'(slot[0]), 0);
    check("launch_a_cnt", 32'(cnt[0]), 1);
    probe_all("launch");

    // Cooldown of 4 on dut_a: the next four presses are dropped, the fifth launches.
    for (int f = 1; f <= 5; f++) begin
      press(int'($urandom_range(0, 3000)), int'($urandom_range(100, 900)));
      frame(-1);
      check($sformatf("cooldown_cnt_a_f%0d", f), 32'(cnt[0]), (f < 5) ? 1 : 2);
    end
    probe_all("cooldown");

    // Retirement at the top edge (dut_a, y=5) and the bottom edge (dut_b, y=1075).
    do_reset();
    press(int'($urandom_range(0, 3000)), 13);
    frame(-1);
    check("retire_top_before", 32'(cnt[0]), 1);
    frame(-1);
    check("retire_top_after", 32'(cnt[0]), 0);
    do_reset();
    press(int'($urandom_range(0, 3000)), 1067);
    frame(-1);
    probe(int'(m_x[1][0]), 1075, "retire_bot_pos");
    frame(-1);
    check("retire_bot_after", 32'(cnt[1]), 0);
    check("retire_bot_a_kept", 32'(cnt[0]), 1);

    // Fill dut_b (no cooldown) one launch per frame, then overflow once.
    do_reset();
    for (int i = 0; i < SLOTS; i++) begin
      press(i * 240 + int'($urandom_range(0, 60)), int'($urandom_range(50, 700)));
      frame(-1);
    end
    check("fill_full_b", 32'(full[1]), 1);
    press(int'($urandom_range(0, 3000)), int'($urandom_range(50, 700)));
    frame(-1);
    check("overflow_full_b", 32'(full[1]), 1);
    probe_all("after_overflow");

    // Hit with calc high is ignored; hit during display removes slot 3 of dut_b.
    frame(3);
    check("calc_hit_ignored_cnt", 32'(cnt[1]), SLOTS);
    hit_pix(m_x[1][3] + 4, m_y[1][3] + 4);
    check("hit_slot3_cnt", 32'(cnt[1]), SLOTS - 1);
    probe_all("after_hit");

    // Reset in the middle of MOVE.
    calc = 1'b1;
    step(8);
    check("mid_move_busy", 32'(busy[0]), 1);
    rst = 1'b1;
    step(1);
    check_zero("mid_move_reset");
    rst = 1'b0;
    calc = 1'b0;
    model_reset();
    step(2);
    check_zero("after_mid_move_reset");

    // Sweep across dut_a's sprite at (200, 300) on row 310; outputs lag by one clock.
    press(152, 308);
    frame(-1);
    col = 12'd195;
    row = 11'd310;
    step(1);
    for (int c = 196; c <= 235; c++) begin
      col = 12'(c);
      #1;
      check_pixel(c - 1, 310, "sweep");
      @(negedge clk);
    end
    check_pixel(235, 310, "sweep_last");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
